// File: rtl/m2p_word_serializer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : m2p_pkg
// Purpose  : Shared widths, the buffered message record and the length
//            legality rule for the method-to-pipe word serializer.
// Revision : 1.0 - initial release
// ============================================================================
package m2p_pkg;

  localparam int MSG_WIDTH  = 128;
  localparam int WORD_WIDTH = 32;
  localparam int LEN_WIDTH  = 16;

  // Header word (word 0) layout.
  localparam int PORTAL_ID_LSB  = 0;
  localparam int PORTAL_ID_MSB  = 15;
  localparam int METHOD_NUM_LSB = 16;
  localparam int METHOD_NUM_MSB = 31;

  typedef struct packed {
    logic [MSG_WIDTH-1:0] v;
    logic [LEN_WIDTH-1:0] length;
  } m2p_msg_t;

  // A message is storable when it carries at least the header word and
  // does not claim more words than the packed payload holds.
  function automatic logic len_is_legal(input logic [LEN_WIDTH-1:0] len,
                                        input int unsigned          maxwords);
    return (len != '0) && (32'(len) <= maxwords);
  endfunction

endpackage
`default_nettype wire

// File: rtl/m2p_word_serializer_if.sv
`default_nettype none
// ============================================================================
// Module   : m2p_word_serializer_if
// Purpose  : Handshake bundle between the indication marshaller (pipe side),
//            the serializer, and the host portal FIFO (out side).
//   pipe_enq__ENA/__RDY/_v/_length : message enqueue handshake
//   out_enq__ENA/__RDY/_v/_last    : word stream toward the portal FIFO
//   master : environment side (drives messages, grants out RDY)
//   slave  : serializer side
// Revision : 1.0 - initial release
// ============================================================================
interface m2p_word_serializer_if;
  import m2p_pkg::*;

  logic                  pipe_enq__ENA;
  logic [MSG_WIDTH-1:0]  pipe_enq_v;
  logic [LEN_WIDTH-1:0]  pipe_enq_length;
  logic                  pipe_enq__RDY;

  logic                  out_enq__ENA;
  logic [WORD_WIDTH-1:0] out_enq_v;
  logic                  out_enq_last;
  logic                  out_enq__RDY;

  modport master (
    output pipe_enq__ENA, pipe_enq_v, pipe_enq_length, out_enq__RDY,
    input  pipe_enq__RDY, out_enq__ENA, out_enq_v, out_enq_last
  );

  modport slave (
    input  pipe_enq__ENA, pipe_enq_v, pipe_enq_length, out_enq__RDY,
    output pipe_enq__RDY, out_enq__ENA, out_enq_v, out_enq_last
  );

endinterface
`default_nettype wire

// File: rtl/m2p_word_serializer_msg_fifo.sv
`default_nettype none
// ============================================================================
// Module   : m2p_msg_fifo
// Purpose  : DEPTH-entry FIFO of m2p_msg_t records with a combinational head.
//   clk, rst : clock, asynchronous active-high reset
//   i_push   : write i_data at the tail (ignored when full)
//   i_pop    : retire the head entry (ignored when empty)
//   o_head   : current head record
//   o_full   : occupancy == DEPTH
//   o_empty  : occupancy == 0
// Revision : 1.0 - initial release
// ============================================================================
module m2p_msg_fifo
  import m2p_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  wire logic     clk,
  input  wire logic     rst,
  input  wire logic     i_push,
  input  wire m2p_msg_t i_data,
  input  wire logic     i_pop,
  output m2p_msg_t      o_head,
  output logic          o_full,
  output logic          o_empty
);

  localparam int c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int c_cnt_w = c_ptr_w + 1;

  m2p_msg_t           r_mem [DEPTH];
  logic [c_ptr_w-1:0] r_head;
  logic [c_ptr_w-1:0] r_tail;
  logic [c_cnt_w-1:0] r_count;

  logic w_push;
  logic w_pop;

  assign o_full  = (r_count == c_cnt_w'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop  & ~o_empty;
  assign o_head  = r_mem[r_head];

  // Storage needs no reset: an entry is only observed once occupancy says so.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_tail] <= i_data;
    end
  end

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_tail <= r_tail + c_ptr_w'(1);
      end
      if (w_pop) begin
        r_head <= r_head + c_ptr_w'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_cnt_w'(1);
        2'b01:   r_count <= r_count - c_cnt_w'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/m2p_word_serializer.sv
`default_nettype none
// ============================================================================
// Module   : m2p_word_serializer
// Purpose  : Buffers packed indication messages and streams each one out as
//            32-bit words, header first, flagging the final word with last.
//            Messages with an illegal length are dropped and counted.
//   CLK, RST  : clock, asynchronous active-high reset
//   m2p       : pipe enqueue (message in) and out enqueue (word out) handshakes
//   err_count : saturating count of discarded messages
// Revision : 1.0 - initial release
// ============================================================================
module m2p_word_serializer
  import m2p_pkg::*;
#(
  parameter int DEPTH    = 2,
  parameter int MAXWORDS = 4,
  parameter int ERRW     = 8
) (
  input  wire logic              CLK,
  input  wire logic              RST,
  m2p_word_serializer_if.slave   m2p,
  output logic [ERRW-1:0]        err_count
);

  localparam int              c_idx_w   = (MAXWORDS > 1) ? $clog2(MAXWORDS) : 1;
  localparam logic [ERRW-1:0] c_err_max = '1;

  m2p_msg_t              w_push_data;
  m2p_msg_t              w_head;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_accept;
  logic                  w_len_ok;
  logic                  w_push;
  logic                  w_bad;
  logic                  w_xfer;
  logic                  w_last;
  logic                  w_pop;
  logic [WORD_WIDTH-1:0] w_words [MAXWORDS];
  logic [WORD_WIDTH-1:0] w_word;

  logic [c_idx_w-1:0]    r_idx;
  logic [ERRW-1:0]       r_err;

  // ---------------------------------------------------------------- enqueue
  // RDY comes from registered occupancy only, so a full buffer refuses a
  // message even in a cycle where the head is being popped.
  assign m2p.pipe_enq__RDY = ~w_full;
  assign w_accept          = m2p.pipe_enq__ENA & ~w_full;
  assign w_len_ok          = len_is_legal(m2p.pipe_enq_length, MAXWORDS);
  assign w_push            = w_accept & w_len_ok;
  assign w_bad             = w_accept & ~w_len_ok;
  assign w_push_data       = '{v: m2p.pipe_enq_v, length: m2p.pipe_enq_length};

  m2p_msg_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (CLK),
    .rst     (RST),
    .i_push  (w_push),
    .i_data  (w_push_data),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // ----------------------------------------------------------------- output
  for (genvar k = 0; k < MAXWORDS; k++) begin : g_words
    assign w_words[k] = w_head.v[k*WORD_WIDTH +: WORD_WIDTH];
  end

  assign w_word = w_words[r_idx];
  assign w_last = ~w_empty &
                  (LEN_WIDTH'(r_idx) == (w_head.length - LEN_WIDTH'(1)));
  assign w_xfer = ~w_empty & m2p.out_enq__RDY;
  assign w_pop  = w_xfer & w_last;

  assign m2p.out_enq__ENA = w_xfer;
  assign m2p.out_enq_v    = w_empty ? '0 : w_word;
  assign m2p.out_enq_last = w_last;

  // Word index walks through the head message; a stalled cycle leaves it
  // (and therefore the presented word) untouched.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_idx <= '0;
    end else if (w_xfer) begin
      if (w_last) begin
        r_idx <= '0;
      end else begin
        r_idx <= r_idx + c_idx_w'(1);
      end
    end
  end

  // ------------------------------------------------------------ error count
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_err <= '0;
    end else if (w_bad && (r_err != c_err_max)) begin
      r_err <= r_err + ERRW'(1);
    end
  end

  assign err_count = r_err;

endmodule
`default_nettype wire

// File: tb/tb_m2p_word_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_m2p_word_serializer
// Purpose  : Self-checking bench for m2p_word_serializer. Every accepted
//            legal message is expanded into its expected word stream and
//            queued; a negedge monitor pops and compares each transfer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_m2p_word_serializer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] err_count;

  m2p_word_serializer_if bus();

  m2p_word_serializer #(
    .DEPTH    (2),
    .MAXWORDS (4),
    .ERRW     (8)
  ) dut (
    .CLK       (clk),
    .RST       (rst),
    .m2p       (bus),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  int         n_vec   = 0;
  int         n_err   = 0;
  int         n_xfer  = 0;
  int         n_last  = 0;
  int         n_legal = 0;
  int         exp_err = 0;
  logic       rand_stall = 1'b0;
  logic [32:0] sb [$];   // {last, word}

  task automatic check(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------- monitor
  always @(negedge clk) begin
    if (!rst) begin
      check("ena_while_rdy_low", 128'(bus.out_enq__ENA & ~bus.out_enq__RDY), 128'd0);
      if (bus.out_enq__ENA) begin
        n_xfer++;
        if (bus.out_enq_last) n_last++;
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_word: got 0x%08h last=%0b, expected no transfer",
                   bus.out_enq_v, bus.out_enq_last);
        end else begin
          logic [32:0] e;
          e = sb.pop_front();
          check("word", {95'd0, bus.out_enq_last, bus.out_enq_v}, {95'd0, e});
        end
      end
    end
  end

  // Random downstream stalls.
  always @(posedge clk) begin
    #1;
    if (rand_stall) bus.out_enq__RDY = 1'($urandom_range(0, 1));
  end

  // -------------------------------------------------------------- stimulus
  // Reference rule: a length in 1..4 yields that many words (word k taken
  // from bits [32k+31:32k]); anything else yields nothing and bumps a
  // counter that stops at 255.
  task automatic send(input logic [127:0] v, input logic [15:0] len);
    int t;
    t = 0;
    while (bus.pipe_enq__RDY !== 1'b1) begin
      @(posedge clk); #1;
      t++;
      if (t > 2000) begin
        n_vec++; n_err++;
        $display("FAIL enq_rdy_timeout: got RDY=%0b, expected 1", bus.pipe_enq__RDY);
        return;
      end
    end
    bus.pipe_enq__ENA   = 1'b1;
    bus.pipe_enq_v      = v;
    bus.pipe_enq_length = len;
    if (len >= 16'd1 && len <= 16'd4) begin
      n_legal++;
      for (int k = 0; k < int'(len); k++) begin
        logic lb;
        lb = (k == int'(len) - 1);
        sb.push_back({lb, v[32*k +: 32]});
      end
    end else if (exp_err < 255) begin
      exp_err++;
    end
    @(posedge clk); #1;
    bus.pipe_enq__ENA = 1'b0;
  endtask

  task automatic drain(input int limit);
    int t;
    t = 0;
    while (sb.size() != 0) begin
      @(posedge clk); #1;
      t++;
      if (t > limit) begin
        n_vec++; n_err++;
        $display("FAIL drain_timeout: got %0d words pending, expected 0", sb.size());
        sb.delete();
        break;
      end
    end
  endtask

  task automatic check_idle(input string name);
    check({name, "_pipe_rdy"}, 128'(bus.pipe_enq__RDY), 128'd1);
    check({name, "_out_ena"},  128'(bus.out_enq__ENA),  128'd0);
    check({name, "_out_v"},    128'(bus.out_enq_v),     128'd0);
    check({name, "_out_last"}, 128'(bus.out_enq_last),  128'd0);
    check({name, "_err"},      128'(err_count),         128'd0);
  endtask

  localparam logic [127:0] c_heard  = {64'd0, 32'h12345678, 16'd2, 16'd5};
  localparam logic [127:0] c_heard2 = {64'd0, 16'h0B0B, 16'h0A0A, 16'd0, 16'd5};
  localparam logic [127:0] c_heard3 = {16'h2222, 32'h01020304, 32'hAABBCCDD,
                                       16'h1111, 16'd1, 16'd5};

  initial begin
    int n0;
    int t;
    bus.pipe_enq__ENA   = 1'b0;
    bus.pipe_enq_v      = '0;
    bus.pipe_enq_length = '0;
    bus.out_enq__RDY    = 1'b1;

    // Reset state
    #2;
    check_idle("reset");
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // heard: two words, first one visible the cycle after the write edge
    send(c_heard, 16'd2);
    check("heard_latency", {95'd0, bus.out_enq__ENA, bus.out_enq_v},
          {95'd0, 1'b1, 32'h00020005});
    drain(50);

    // heard3: four words
    send(c_heard3, 16'd4);
    drain(50);

    // Back-to-back with output stalled: buffer fills, header holds
    bus.out_enq__RDY = 1'b0;
    send(c_heard2, 16'd2);
    send(c_heard,  16'd2);
    check("full_pipe_rdy", 128'(bus.pipe_enq__RDY), 128'd0);
    check("stall_word", 128'(bus.out_enq_v), 128'h5);
    repeat (3) @(posedge clk);
    #1;
    check("stall_hold", 128'(bus.out_enq_v), 128'h5);
    n0 = n_xfer;
    bus.out_enq__RDY = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("no_bubble_xfers", 128'(n_xfer - n0), 128'd4);
    check("no_bubble_pending", 128'(sb.size()), 128'd0);

    // Illegal lengths: dropped and counted, counter saturates
    send(128'($urandom), 16'd0);
    send(128'($urandom), 16'd5);
    send(128'($urandom), 16'hFFFF);
    repeat (3) @(posedge clk);
    #1;
    check("err_three", 128'(err_count), 128'(exp_err));
    check("err_no_output", 128'(bus.out_enq__ENA), 128'd0);
    for (int i = 0; i < 253; i++) begin
      logic [15:0] bl;
      bl = (i % 7 == 0) ? 16'd0 : 16'($urandom_range(5, 65535));
      send({$urandom, $urandom, $urandom, $urandom}, bl);
    end
    #1;
    check("err_sat", 128'(err_count), 128'(exp_err));
    send(128'd0, 16'd0);
    send(128'd0, 16'd9);
    #1;
    check("err_sat_hold", 128'(err_count), 128'd255);

    // Reset mid-message after two words of heard3
    n0 = n_xfer;
    send(c_heard3, 16'd4);
    t = 0;
    while (n_xfer < n0 + 2 && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    check("mid_words_seen", 128'(n_xfer - n0), 128'd2);
    #2;
    rst = 1'b1;
    #1;
    check_idle("mid_reset");
    sb.delete();
    exp_err = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    send(c_heard, 16'd2);
    check("post_reset_word0", {95'd0, bus.out_enq__ENA, bus.out_enq_v},
          {95'd0, 1'b1, 32'h00020005});
    drain(50);

    // Random legal traffic with random stalls
    n_last  = 0;
    n_legal = 0;
    rand_stall = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      send({$urandom, $urandom, $urandom, $urandom}, 16'($urandom_range(1, 4)));
    end
    rand_stall = 1'b0;
    @(posedge clk); #2;
    bus.out_enq__RDY = 1'b1;
    drain(200);
    #1;
    check("last_count", 128'(n_last), 128'(n_legal));
    check("rand_err", 128'(err_count), 128'(exp_err));
    check("sb_empty", 128'(sb.size()), 128'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/m2p_word_serializer.md
Name: m2p_word_serializer

Overview:
- Sits directly downstream of the method-to-pipe indication marshaller.
- Consumes its `pipe$enq` transactions: a 128-bit packed message plus a length in 32-bit words.
- Buffers up to DEPTH messages and emits each as a stream of 32-bit words, header word first, toward the host portal FIFO.
- Marks the final word of each message with `last`, and discards malformed lengths with an error count.

Parameters:
- DEPTH, 2, message buffer entries (power of two, ≥2)
- MAXWORDS, 4, maximum legal message length in 32-bit words (128/32)
- ERRW, 8, width of the saturating error counter

Ports:
- CLK  input  1  clock
- RST  input  1  asynchronous, active-high reset
- pipe$enq__ENA  input  1  message enqueue strobe; asserted only while `pipe$enq__RDY`=1
- pipe$enq$v  input  128  packed message; word k = bits [32k+31:32k]; word 0 = {methodNumber[15:0], portalId[15:0]}
- pipe$enq$length  input  16  message length in 32-bit words
- pipe$enq__RDY  output  1  buffer can accept a message this cycle
- out$enq__ENA  output  1  word transfer this cycle
- out$enq$v  output  32  current word
- out$enq$last  output  1  current word is the last of its message
- out$enq__RDY  input  1  downstream can accept a word
- err_count  output  ERRW  saturating count of discarded messages

Behaviour:
- Reset (asynchronous, active-high): FIFO empty, word index 0, `err_count` 0.
  - Output values during reset: `pipe$enq__RDY`=1, `out$enq__ENA`=0, `out$enq$v`=0, `out$enq$last`=0.
- Reset mid-message: the partial message is lost; no `last` is emitted for it.
- Enqueue side:
  - `pipe$enq__RDY` = (occupancy < DEPTH), taken from registered occupancy only; no same-cycle pass-through when full, even if a pop occurs that cycle.
  - On `__ENA`, {v, length} is written to the tail entry on the next edge.
- Length check at enqueue:
  - Length 0, or length > MAXWORDS, is still accepted (RDY honoured) but not stored.
  - `err_count` increments by 1 and saturates at 2^ERRW−1.
  - Length 1 is legal (header-only message).
- Output side:
  - `out$enq__ENA` = FIFO non-empty & `out$enq__RDY`. ENA is never asserted while RDY is low.
  - `out$enq$v` = head.v word[idx]; 0 when the FIFO is empty.
  - `out$enq$last` = (idx == head.length−1) & non-empty.
- Word index idx (2 bits):
  - On a transfer with last=1: pop the head, idx←0.
  - On a transfer with last=0: idx←idx+1.
  - If `out$enq__RDY` stalls, idx and head hold; the presented word is stable.
- Latency: a message written at edge N presents word 0 from cycle N+1. Sustained throughput is 1 word/cycle with back-to-back messages and no bubble between them.
- Simultaneous enqueue and pop: both occur; occupancy is unchanged.
- Pointers: head/tail wrap modulo DEPTH. Occupancy counter is $clog2(DEPTH)+1 bits.
- Bits of v above 32·length are ignored.

Decomposition:
- Shared package `m2p_pkg`:
  - `MSG_WIDTH`=128, `WORD_WIDTH`=32, `LEN_WIDTH`=16
  - typedef `m2p_msg_t` {v[127:0], length[15:0]}
  - header field offsets (portalId [15:0], methodNumber [31:16])
- One sub-module: `m2p_msg_fifo` (DEPTH×`m2p_msg_t`, push/pop/full/empty). The serializer's word-index logic stays in the top.

Test Plan:
- heard(v=0x12345678): v={0x12345678,16'd2,16'd5}, length=2, RDY held high → words 0x00020005 (last=0), then 0x12345678 (last=1) on consecutive cycles.
- heard3(a=0x1111, b=0xAABBCCDD, c=0x01020304, d=0x2222), length=4 → 0x00010005, 0xCCDD1111, 0x0304AABB, 0x22220102; last only on the 4th word.
- Back-to-back heard2(a=0x0A0A, b=0x0B0B) then heard: two messages enqueued on consecutive cycles, with `out$enq__RDY` low for 5 cycles → `pipe$enq__RDY` drops to 0 after 2 enqueues; output holds 0x00000005. When RDY rises, 0x00000005, 0x0B0B0A0A(last), 0x00020005, v(last) stream with no bubble.
- Lengths 0, 5 and 16'hFFFF enqueued → no output words, `err_count`=3. Then 253 more illegal lengths → `err_count` saturates at 255.
- Assert RST mid-way through a heard3 message (after 2 words) → outputs go to 0 asynchronously, `pipe$enq__RDY`=1, `err_count`=0. After release, a new heard message streams from word 0.
- Random stall injection on `out$enq__RDY` over 1000 random legal messages → scoreboard matches every word; `out$enq__ENA` never high while RDY low; `last` count equals accepted legal messages.
